// File: rtl/mem_test_status_pkg.sv
// Shared types and constants for the memory-test status block.
// Holds LED modes, blink FSM states and the fail-code helper.
package mem_test_status_pkg;

   typedef enum logic [1:0] {
      MODE_HEARTBEAT = 2'd0,
      MODE_STATUS    = 2'd1,
      MODE_FAILCODE  = 2'd2,
      MODE_OFF       = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      BL_IDLE,
      BL_ON,
      BL_OFF,
      BL_GAP
   } blink_e;

   localparam int GAP_TICKS = 4;
   localparam int MAX_CH    = 8;

   // Blink count: index of lowest failing channel plus one.
   function automatic logic [3:0] fail_code(
      input logic [MAX_CH-1:0] m
   );
      logic [3:0] c;
      c = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (m[i]) c = 4'(i + 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/mem_test_status_blink.sv
// Blink-code FSM: flashes the lowest failing channel number,
// then pauses, re-latching the code only between sequences.
module mem_test_status_blink
   import mem_test_status_pkg::*;
#(
   parameter int NUM_CH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              en,
   input  logic [NUM_CH-1:0] fail_mask,
   output logic              led
);

   blink_e      state_q, state_d;
   logic [3:0]  rem_q, rem_d;
   logic [1:0]  gap_q, gap_d;
   logic [MAX_CH-1:0] mask_ext;

   assign mask_ext = MAX_CH'(fail_mask);
   assign led      = (state_q == BL_ON);

   // State register for the blink sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BL_IDLE;
         rem_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
      end
   end

   // Advance one step per tick; dropping en parks in IDLE.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      if (!en) begin
         state_d = BL_IDLE;
         rem_d   = '0;
         gap_d   = '0;
      end else if (tick) begin
         unique case (state_q)
            BL_IDLE: begin
               if (|fail_mask) begin
                  rem_d   = fail_code(mask_ext);
                  state_d = BL_ON;
               end
            end
            BL_ON: begin
               rem_d   = rem_q - 4'd1;
               state_d = BL_OFF;
            end
            BL_OFF: begin
               if (rem_q != 4'd0) begin
                  state_d = BL_ON;
               end else begin
                  state_d = BL_GAP;
                  gap_d   = '0;
               end
            end
            BL_GAP: begin
               if (gap_q == 2'(GAP_TICKS - 1)) begin
                  state_d = BL_IDLE;
               end else begin
                  gap_d = gap_q + 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_test_status.sv
// Per-channel memory-test completion/failure tracking with
// counters, sticky fail flags and a mode-selected status LED.
module mem_test_status
   import mem_test_status_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int CNT_WIDTH  = 8,
   parameter int TICK_WIDTH = 22,
   parameter int SATURATE   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             test_done,
   input  logic [NUM_CH-1:0]             test_pass,
   input  logic                          clr,
   input  logic [1:0]                    mode,
   output logic [NUM_CH*CNT_WIDTH-1:0]   done_cnt,
   output logic [NUM_CH*CNT_WIDTH-1:0]   fail_cnt,
   output logic [NUM_CH-1:0]             fail_mask,
   output logic                          pass_all,
   output logic                          led
);

   logic [CNT_WIDTH-1:0]  dcnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  dcnt_d [NUM_CH];
   logic [CNT_WIDTH-1:0]  fcnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0]  fcnt_d [NUM_CH];
   logic [NUM_CH-1:0]     tdq_q, mask_q, mask_d;
   logic [NUM_CH-1:0]     seen_q, seen_d, ev;
   logic                  armed_q, pass_q, pass_d;
   logic [TICK_WIDTH-1:0] presc_q, presc_d;
   logic                  tick_q, tick_d;
   logic                  led_q, led_d;
   logic                  blink_en, blink_led;

   function automatic logic [CNT_WIDTH-1:0] bump(
      input logic [CNT_WIDTH-1:0] v
   );
      if (SATURATE != 0 && (&v)) return v;
      return v + CNT_WIDTH'(1);
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign done_cnt[g*CNT_WIDTH +: CNT_WIDTH] = dcnt_q[g];
      assign fail_cnt[g*CNT_WIDTH +: CNT_WIDTH] = fcnt_q[g];
   end

   assign fail_mask = mask_q;
   assign pass_all  = pass_q;
   assign led       = led_q;
   assign blink_en  = (mode == MODE_FAILCODE) & ~clr;

   // Edge detection, counting and sticky flags; clr wins.
   always_comb begin
      ev     = armed_q ? (test_done & ~tdq_q) : '0;
      mask_d = mask_q;
      seen_d = seen_q;
      for (int c = 0; c < NUM_CH; c++) begin
         dcnt_d[c] = dcnt_q[c];
         fcnt_d[c] = fcnt_q[c];
         if (clr) begin
            dcnt_d[c] = '0;
            fcnt_d[c] = '0;
            mask_d[c] = 1'b0;
            seen_d[c] = 1'b0;
         end else if (ev[c]) begin
            dcnt_d[c] = bump(dcnt_q[c]);
            seen_d[c] = 1'b1;
            if (!test_pass[c]) begin
               fcnt_d[c] = bump(fcnt_q[c]);
               mask_d[c] = 1'b1;
            end
         end
      end
      pass_d = (&seen_d) & ~(|mask_d);
   end

   // Prescaler, tick pulse and LED source selection.
   always_comb begin
      presc_d = presc_q + TICK_WIDTH'(1);
      tick_d  = &presc_q;
      led_d   = 1'b0;
      unique case (mode_e'(mode))
         MODE_HEARTBEAT: led_d = dcnt_q[0][CNT_WIDTH-1];
         MODE_STATUS:
            led_d = pass_q |
                    ((|mask_q) & presc_q[TICK_WIDTH-1]);
         MODE_FAILCODE:  led_d = blink_led & ~clr;
         MODE_OFF:       led_d = 1'b0;
      endcase
   end

   // All status state; armed_q holds off counting one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            dcnt_q[c] <= '0;
            fcnt_q[c] <= '0;
         end
         tdq_q   <= '0;
         mask_q  <= '0;
         seen_q  <= '0;
         armed_q <= 1'b0;
         pass_q  <= 1'b0;
         presc_q <= '0;
         tick_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            dcnt_q[c] <= dcnt_d[c];
            fcnt_q[c] <= fcnt_d[c];
         end
         tdq_q   <= test_done;
         mask_q  <= mask_d;
         seen_q  <= seen_d;
         armed_q <= 1'b1;
         pass_q  <= pass_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         led_q   <= led_d;
      end
   end

   mem_test_status_blink #(
      .NUM_CH (NUM_CH)
   ) u_blink (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick_q),
      .en        (blink_en),
      .fail_mask (mask_q),
      .led       (blink_led)
   );

endmodule

// File: tb/tb_mem_test_status.sv
// Bench for mem_test_status: saturating and wrapping copies
// share stimulus and are checked against a queue-based model.
module tb_mem_test_status;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] test_done, test_pass, mode;
   logic       clr;
   logic [7:0] dc_s, fc_s, dc_w, fc_w;
   logic [1:0] fm_s, fm_w;
   logic       pa_s, pa_w, led_s, led_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_test_status #(
      .NUM_CH(2), .CNT_WIDTH(4), .TICK_WIDTH(4), .SATURATE(1)
   ) u_sat (
      .clk(clk), .rst_n(rst_n), .test_done(test_done),
      .test_pass(test_pass), .clr(clr), .mode(mode),
      .done_cnt(dc_s), .fail_cnt(fc_s), .fail_mask(fm_s),
      .pass_all(pa_s), .led(led_s)
   );

   mem_test_status #(
      .NUM_CH(2), .CNT_WIDTH(4), .TICK_WIDTH(4), .SATURATE(0)
   ) u_wrap (
      .clk(clk), .rst_n(rst_n), .test_done(test_done),
      .test_pass(test_pass), .clr(clr), .mode(mode),
      .done_cnt(dc_w), .fail_cnt(fc_w), .fail_mask(fm_w),
      .pass_all(pa_w), .led(led_w)
   );

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pk(int hi, int lo);
      return {hi[3:0], lo[3:0]};
   endfunction

   // Model: k=0 saturating copy, k=1 wrapping copy
   int         m_d [2][2];
   int         m_f [2][2];
   logic [1:0] m_mask, m_seen, m_prev, m_ev;
   logic       m_armed, m_pass, m_tick, b_on;
   logic       m_led [2];
   int         m_presc, code;
   int         bq [$];

   always @(posedge clk or negedge rst_n) begin : model
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
               m_d[k][c] = 0;
               m_f[k][c] = 0;
            end
            m_led[k] = 1'b0;
         end
         m_mask = 0; m_seen = 0; m_prev = 0;
         m_armed = 0; m_pass = 0; m_tick = 0;
         m_presc = 0;
         bq.delete();
      end else begin
         b_on = (bq.size() > 0) && (bq[0] == 1);
         for (int k = 0; k < 2; k++) begin
            case (mode)
               2'd0: m_led[k] = (m_d[k][0] >= 8);
               2'd1: m_led[k] = m_pass ||
                        (m_mask != 0 && m_presc >= 8);
               2'd2: m_led[k] = b_on && !clr;
               default: m_led[k] = 1'b0;
            endcase
         end
         if (mode != 2'd2 || clr) begin
            bq.delete();
         end else if (m_tick) begin
            if (bq.size() > 0) begin
               void'(bq.pop_front());
            end else if (m_mask != 0) begin
               code = m_mask[0] ? 1 : 2;
               for (int i = 0; i < code; i++) begin
                  bq.push_back(1);
                  bq.push_back(0);
               end
               repeat (4) bq.push_back(0);
            end
         end
         m_ev = m_armed ? (test_done & ~m_prev) : 2'b00;
         for (int c = 0; c < 2; c++) begin
            if (clr) begin
               for (int k = 0; k < 2; k++) begin
                  m_d[k][c] = 0;
                  m_f[k][c] = 0;
               end
               m_mask[c] = 0;
               m_seen[c] = 0;
            end else if (m_ev[c]) begin
               m_seen[c] = 1;
               m_d[0][c] = (m_d[0][c] < 15) ? m_d[0][c] + 1 : 15;
               m_d[1][c] = (m_d[1][c] + 1) % 16;
               if (!test_pass[c]) begin
                  m_mask[c] = 1;
                  m_f[0][c] = (m_f[0][c] < 15) ?
                              m_f[0][c] + 1 : 15;
                  m_f[1][c] = (m_f[1][c] + 1) % 16;
               end
            end
         end
         m_pass  = (m_seen == 2'b11) && (m_mask == 2'b00);
         m_tick  = (m_presc == 15);
         m_presc = (m_presc + 1) % 16;
         m_prev  = test_done;
         m_armed = 1'b1;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("done_s", dc_s, pk(m_d[0][1], m_d[0][0]));
         chk("fail_s", fc_s, pk(m_f[0][1], m_f[0][0]));
         chk("done_w", dc_w, pk(m_d[1][1], m_d[1][0]));
         chk("fail_w", fc_w, pk(m_f[1][1], m_f[1][0]));
         chk("mask_s", fm_s, m_mask);
         chk("mask_w", fm_w, m_mask);
         chk("pass_s", pa_s, m_pass);
         chk("pass_w", pa_w, m_pass);
         chk("led_s", led_s, m_led[0]);
         chk("led_w", led_w, m_led[1]);
      end
   end

   task automatic tk(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin : stim
      int tg, hi, ons, w;
      logic pv;
      rst_n = 1'b0;
      test_done = 2'b01;
      test_pass = 2'b11;
      clr = 1'b0;
      mode = 2'd0;
      #12;
      chk("rst_done", dc_s, 0);
      chk("rst_mask", fm_s, 0);
      chk("rst_pass", pa_s, 0);
      chk("rst_led", led_s, 0);
      tk(1);
      rst_n = 1'b1;
      tk(5);
      chk("held_thru_rst", dc_s, 0);
      test_done = 2'b00;
      tk(1);
      test_done = 2'b01;
      tk(50);
      chk("hold50_done", dc_s, 8'h01);
      chk("hold50_fail", fc_s, 8'h00);
      chk("hold50_pass", pa_s, 0);
      test_done = 2'b11;
      tk(2);
      chk("both_pass", pa_s, 1);
      chk("both_done", dc_w, 8'h11);
      mode = 2'd1;
      tk(2);
      chk("m1_pass_led", led_s, 1);
      mode = 2'd3;
      tk(2);
      chk("m3_led", led_s, 0);
      mode = 2'd0;

      test_done = 2'b00;
      tk(1);
      clr = 1'b1;
      tk(1);
      clr = 1'b0;
      chk("clr_done", dc_s, 0);
      for (int i = 0; i < 20; i++) begin
         test_done = 2'b01;
         tk(1);
         test_done = 2'b00;
         tk(1);
      end
      tk(2);
      chk("sat20", dc_s, 8'h0f);
      chk("wrap20", dc_w, 8'h04);
      chk("sat_led", led_s, 1);
      chk("wrap_led", led_w, 0);

      clr = 1'b1;
      tk(1);
      clr = 1'b0;
      mode = 2'd1;
      test_pass = 2'b01;
      test_done = 2'b10;
      tk(1);
      test_done = 2'b00;
      tk(2);
      chk("f1_mask", fm_s, 2'b10);
      chk("f1_cnt", fc_s, 8'h10);
      chk("f1_pass", pa_s, 0);
      tg = 0;
      pv = led_s;
      repeat (64) begin
         tk(1);
         if (led_s != pv) tg++;
         pv = led_s;
      end
      chk("m1_toggles", tg, 8);

      mode = 2'd2;
      test_pass = 2'b11;
      tk(1);
      pv = led_s;
      hi = 0;
      ons = 0;
      repeat (288) begin
         tk(1);
         if (led_s && !pv) ons++;
         if (led_s) hi++;
         pv = led_s;
      end
      chk("blink_ons", ons, 4);
      chk("blink_hi", hi, 64);

      w = 0;
      while (led_s !== 1'b1 && w < 300) begin
         tk(1);
         w++;
      end
      chk("wait_on", led_s, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_led", led_s, 0);
      chk("arst_mask", fm_s, 0);
      chk("arst_fail", fc_s, 0);
      chk("arst_done", dc_s, 0);
      tk(2);
      rst_n = 1'b1;
      tk(40);
      chk("post_rst_led", led_s, 0);

      mode = 2'd0;
      test_done = 2'b01;
      tk(1);
      test_done = 2'b00;
      tk(1);
      chk("pre_clr_done", dc_s, 8'h01);
      test_done = 2'b01;
      clr = 1'b1;
      tk(1);
      clr = 1'b0;
      chk("clr_edge_s", dc_s, 0);
      chk("clr_edge_w", dc_w, 0);
      tk(10);
      chk("clr_hold_done", dc_s, 0);
      chk("clr_hold_mask", fm_s, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
